// File: rtl/rnd_backoff_pkg.sv
// ============================================================================
// Module   : rnd_backoff_pkg
// Purpose  : Shared types and the period calculation for the randomised
//            retransmission backoff timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rnd_backoff_pkg;

  // Controller states: idle, timing a window, waiting for a retry decision
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } backoff_state_t;

  localparam int unsigned C_BASE_W = 16;
  localparam int unsigned C_ATT_W  = 4;
  localparam int unsigned C_CALC_W = 64;

  // Window length in ticks: (base << shift) + jitter, never zero.
  // Worked in a wide intermediate so nothing is lost before the caller
  // narrows it to its own counter width.
  function automatic logic [C_CALC_W-1:0] calc_period(
    input logic [C_BASE_W-1:0] base,
    input logic [C_ATT_W-1:0]  shift,
    input logic [C_CALC_W-1:0] jit
  );
    logic [C_CALC_W-1:0] p;
    p = ({{(C_CALC_W-C_BASE_W){1'b0}}, base} << shift) + jit;
    if (p == '0) begin
      p = {{(C_CALC_W-1){1'b0}}, 1'b1};
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rnd_backoff_tick_gen.sv
// ============================================================================
// Module   : rnd_backoff_tick_gen
// Purpose  : Prescaler producing a one-cycle tick every TICK_DIV enabled
//            clocks; a synchronous clear restarts the count from zero so the
//            first tick after an arm lands exactly TICK_DIV cycles later.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rnd_backoff_tick_gen #(
  parameter int unsigned TICK_DIV = 125000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  // With TICK_DIV=1 a single bit that stays at zero gives a tick every cycle
  localparam int unsigned          PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]        C_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  // Next prescaler value: clear wins, otherwise count and wrap while enabled
  always_comb begin
    presc_d = presc_q;
    if (clr_i) begin
      presc_d = '0;
    end else if (en_i) begin
      presc_d = (presc_q == C_LAST) ? '0 : presc_q + PW'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick_o = en_i && (presc_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/rnd_backoff.sv
// ============================================================================
// Module   : rnd_backoff
// Purpose  : Randomised retransmission/backoff timer. Each arm samples the
//            PRNG word and times (BASE << min(attempt,MAX_SHIFT)) + jitter
//            ticks, pulses expired on timeout and reports exhaustion once a
//            retry is requested beyond MAX_RETRY.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rnd_backoff
  import rnd_backoff_pkg::*;
#(
  parameter int unsigned W           = 32,
  parameter int unsigned TICK_DIV    = 125000,
  parameter int unsigned BASE_TICKS  = 1000,
  parameter int unsigned JITTER_BITS = 8,
  parameter int unsigned MAX_SHIFT   = 4,
  parameter int unsigned MAX_RETRY   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] rnd_i,
  input  logic         start_i,
  input  logic         retry_i,
  input  logic         abort_i,
  output logic         busy_o,
  output logic         expired_o,
  output logic         exhausted_o,
  output logic [3:0]   attempt_o
);

  // Counter wide enough for the largest shifted base plus the jitter term
  localparam int unsigned CW = ((16 + MAX_SHIFT >= JITTER_BITS) ? (16 + MAX_SHIFT)
                                                               : JITTER_BITS) + 1;

  localparam logic [C_BASE_W-1:0] C_BASE      = C_BASE_W'(BASE_TICKS);
  localparam logic [C_ATT_W-1:0]  C_MAX_SHIFT = C_ATT_W'(MAX_SHIFT);
  localparam logic [C_ATT_W-1:0]  C_MAX_RETRY = C_ATT_W'(MAX_RETRY);

  backoff_state_t      state_q;
  backoff_state_t      state_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [C_ATT_W-1:0]  attempt_q;
  logic [C_ATT_W-1:0]  attempt_d;
  logic                exhausted_q;
  logic                exhausted_d;

  logic                w_arm;
  logic                w_abort;
  logic                w_run;
  logic                w_tick;
  logic                w_final;
  logic [C_ATT_W-1:0]  w_shift;
  logic [C_CALC_W-1:0] w_jit;
  logic [CW-1:0]       w_period;

  // Only the low jitter bits matter; the rest of the word is intentionally ignored
  logic                w_unused_rnd;
  assign w_unused_rnd = ^rnd_i;

  generate
    if (JITTER_BITS == 0) begin : g_jit_none
      assign w_jit = '0;
    end else begin : g_jit
      assign w_jit = C_CALC_W'(rnd_i[JITTER_BITS-1:0]);
    end
  endgenerate

  assign w_run   = (state_q == RUN);
  assign w_final = w_tick && (cnt_q == CW'(1));

  // The window is sized from the attempt index that the arm is about to use
  assign w_shift  = (attempt_d > C_MAX_SHIFT) ? C_MAX_SHIFT : attempt_d;
  assign w_period = CW'(calc_period(C_BASE, w_shift, w_jit));

  rnd_backoff_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (w_run),
    .clr_i  (w_arm | w_abort),
    .tick_o (w_tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus attempt/exhausted bookkeeping; abort > start > retry
  always_comb begin
    state_d     = state_q;
    attempt_d   = attempt_q;
    exhausted_d = exhausted_q;
    w_arm       = 1'b0;
    w_abort     = 1'b0;
    case (state_q)
      IDLE: begin
        // abort is a no-op here but still masks a simultaneous start
        if (start_i && !abort_i) begin
          w_arm       = 1'b1;
          attempt_d   = '0;
          exhausted_d = 1'b0;
          state_d     = RUN;
        end
      end
      RUN, WAIT: begin
        if (abort_i) begin
          w_abort     = 1'b1;
          attempt_d   = '0;
          exhausted_d = 1'b0;
          state_d     = IDLE;
        end else if (start_i) begin
          w_arm       = 1'b1;
          attempt_d   = '0;
          exhausted_d = 1'b0;
          state_d     = RUN;
        end else if (retry_i) begin
          if (attempt_q < C_MAX_RETRY) begin
            w_arm     = 1'b1;
            attempt_d = attempt_q + C_ATT_W'(1);
            state_d   = RUN;
          end else begin
            // Out of retries: attempt holds its final value for inspection
            exhausted_d = 1'b1;
            state_d     = IDLE;
          end
        end else if ((state_q == RUN) && w_final) begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Tick countdown: load the sampled period on arm, step once per tick
  always_comb begin
    cnt_d = cnt_q;
    if (w_arm) begin
      cnt_d = w_period;
    end else if (w_run && w_tick) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      attempt_q   <= '0;
      exhausted_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      attempt_q   <= attempt_d;
      exhausted_q <= exhausted_d;
    end
  end

  // Outputs; expired fires on the final tick itself unless aborted that cycle
  always_comb begin
    busy_o      = w_run;
    expired_o   = w_run && w_final && !abort_i;
    exhausted_o = exhausted_q;
    attempt_o   = attempt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_rnd_backoff.sv
// ============================================================================
// Module   : tb_rnd_backoff
// Purpose  : Self-checking bench for rnd_backoff: directed vector table,
//            multi-cycle timing sequences and a randomised run against a
//            deadline-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rnd_backoff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  s_start, s_retry, s_abort;
  logic [31:0] s_rnd [3];
  logic [2:0]  o_busy, o_exp, o_exh;
  logic [3:0]  o_att [3];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  // dut 0: main configuration
  rnd_backoff #(.W(32), .TICK_DIV(1), .BASE_TICKS(3), .JITTER_BITS(2),
                .MAX_SHIFT(2), .MAX_RETRY(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rnd_i(s_rnd[0]), .start_i(s_start[0]),
    .retry_i(s_retry[0]), .abort_i(s_abort[0]), .busy_o(o_busy[0]),
    .expired_o(o_exp[0]), .exhausted_o(o_exh[0]), .attempt_o(o_att[0]));

  // dut 1: prescaled ticks, no jitter
  rnd_backoff #(.W(32), .TICK_DIV(4), .BASE_TICKS(2), .JITTER_BITS(0),
                .MAX_SHIFT(2), .MAX_RETRY(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rnd_i(s_rnd[1]), .start_i(s_start[1]),
    .retry_i(s_retry[1]), .abort_i(s_abort[1]), .busy_o(o_busy[1]),
    .expired_o(o_exp[1]), .exhausted_o(o_exh[1]), .attempt_o(o_att[1]));

  // dut 2: zero base, period can collapse to the forced minimum
  rnd_backoff #(.W(32), .TICK_DIV(1), .BASE_TICKS(0), .JITTER_BITS(2),
                .MAX_SHIFT(2), .MAX_RETRY(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .rnd_i(s_rnd[2]), .start_i(s_start[2]),
    .retry_i(s_retry[2]), .abort_i(s_abort[2]), .busy_o(o_busy[2]),
    .expired_o(o_exp[2]), .exhausted_o(o_exh[2]), .attempt_o(o_att[2]));

  typedef struct {
    bit          st, rt, ab;
    logic [31:0] rnd;
    bit          busy, expd, exh;
    logic [3:0]  att;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit st, input bit rt, input bit ab, input int unsigned rv,
                     input bit b, input bit e, input bit x, input int a);
    vec_t v;
    v.st = st; v.rt = rt; v.ab = ab; v.rnd = rv;
    v.busy = b; v.expd = e; v.exh = x; v.att = 4'(a);
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pulse start/retry on dut d, then count cycles to the expiry pulse
  task automatic pulse_wait(input int d, input bit s, input bit r, input logic [31:0] rv,
                            input int exp_p, input string nm);
    int k;
    bit found;
    @(posedge clk); #1;
    s_start[d] = s; s_retry[d] = r; s_rnd[d] = rv;
    @(posedge clk); #1;
    s_start[d] = 1'b0; s_retry[d] = 1'b0; s_rnd[d] = $urandom;
    k = 1;
    found = 1'b0;
    while (!found && k <= 200) begin
      @(negedge clk);
      if (o_exp[d] === 1'b1) found = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk(nm, found ? k : -1, exp_p);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_pulse"}, o_exp[d], 0);
    chk({nm, "_busy"}, o_busy[d], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_e;
    int m_mode, m_att, m_dl;
    bit m_exh;

    rst_n = 1'b0;
    s_start = '0; s_retry = '0; s_abort = '0;
    for (int i = 0; i < 3; i++) s_rnd[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---------------- directed vector table on dut 0 ----------------
    //   st rt ab rnd   busy exp exh att
    add(0, 0, 0, 0,   0, 0, 0, 0);  // 0 reset state
    add(1, 0, 0, 0,   0, 0, 0, 0);  // 1 start, P=3
    add(0, 0, 0, 3,   1, 0, 0, 0);  // 2 rnd change ignored
    add(0, 0, 0, 3,   1, 0, 0, 0);  // 3
    add(0, 0, 0, 3,   1, 1, 0, 0);  // 4 expiry
    add(0, 0, 0, 0,   0, 0, 0, 0);  // 5 WAIT
    add(0, 1, 0, 0,   0, 0, 0, 0);  // 6 retry -> attempt 1, P=6
    add(0, 0, 1, 0,   1, 0, 0, 1);  // 7 abort in RUN
    add(0, 0, 0, 0,   0, 0, 0, 0);  // 8 IDLE
    add(1, 0, 0, 2,   0, 0, 0, 0);  // 9 start, P=5, deadline row 14
    add(0, 0, 0, 0,   1, 0, 0, 0);  // 10
    add(0, 0, 0, 0,   1, 0, 0, 0);  // 11
    add(0, 0, 0, 0,   1, 0, 0, 0);  // 12
    add(0, 0, 0, 0,   1, 0, 0, 0);  // 13
    add(0, 0, 1, 0,   1, 0, 0, 0);  // 14 abort on expiry cycle
    add(0, 0, 0, 0,   0, 0, 0, 0);  // 15
    add(1, 0, 0, 0,   0, 0, 0, 0);  // 16 start, P=3
    add(0, 1, 0, 0,   1, 0, 0, 0);  // 17 early retry -> attempt 1
    add(1, 1, 0, 0,   1, 0, 0, 1);  // 18 start+retry -> attempt 0
    add(1, 1, 1, 0,   1, 0, 0, 0);  // 19 all three -> abort wins
    add(0, 0, 0, 0,   0, 0, 0, 0);  // 20 IDLE
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      s_start[0] = vq[i].st; s_retry[0] = vq[i].rt; s_abort[0] = vq[i].ab;
      s_rnd[0] = vq[i].rnd;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), o_busy[0], vq[i].busy);
      chk($sformatf("vec%0d_expired", i), o_exp[0], vq[i].expd);
      chk($sformatf("vec%0d_exhausted", i), o_exh[0], vq[i].exh);
      chk($sformatf("vec%0d_attempt", i), o_att[0], vq[i].att);
    end
    @(posedge clk); #1;
    s_start[0] = 1'b0; s_retry[0] = 1'b0; s_abort[0] = 1'b0;

    // ---------------- retry ladder and exhaustion on dut 0 ----------------
    pulse_wait(0, 1'b1, 1'b0, 32'h1, 4, "ladder_p0");
    pulse_wait(0, 1'b0, 1'b1, 32'h5, 7, "ladder_p1");
    pulse_wait(0, 1'b0, 1'b1, 32'hD, 13, "ladder_p2");
    chk("ladder_attempt", o_att[0], 2);
    @(posedge clk); #1 s_retry[0] = 1'b1;
    @(posedge clk); #1 s_retry[0] = 1'b0;
    @(negedge clk);
    chk("exhaust_flag", o_exh[0], 1);
    chk("exhaust_busy", o_busy[0], 0);
    chk("exhaust_attempt", o_att[0], 2);
    cnt_e = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_exp[0] === 1'b1) cnt_e++;
    end
    chk("exhaust_no_expiry", cnt_e, 0);
    pulse_wait(0, 1'b1, 1'b0, 32'h1, 4, "restart_p0");
    chk("restart_exhausted", o_exh[0], 0);
    chk("restart_attempt", o_att[0], 0);

    // ---------------- forced minimum period on dut 2 ----------------
    pulse_wait(2, 1'b1, 1'b0, 32'h0, 1, "zero_period");
    pulse_wait(2, 1'b1, 1'b0, 32'h3, 3, "zero_base_jit3");

    // ---------------- prescaled timing and reset on dut 1 ----------------
    pulse_wait(1, 1'b1, 1'b0, $urandom, 8, "div4_period");
    @(posedge clk); #1 s_start[1] = 1'b1;          // cycle N
    @(posedge clk); #1 s_start[1] = 1'b0;          // N+1
    repeat (3) @(posedge clk);                     // N+4
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy_before", o_busy[1], 1);
    @(posedge clk); #1;                            // N+5
    @(negedge clk);
    chk("rst_busy", o_busy[1], 0);
    chk("rst_expired", o_exp[1], 0);
    chk("rst_exhausted", o_exh[1], 0);
    chk("rst_attempt", o_att[1], 0);
    rst_n = 1'b1;
    cnt_e = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_exp[1] === 1'b1) cnt_e++;
    end
    chk("rst_no_expiry", cnt_e, 0);

    // ---------------- randomised run on dut 0 vs deadline model ----------------
    m_mode = 0; m_att = 0; m_exh = 1'b0; m_dl = 0;
    for (int c = 0; c < 3000; c++) begin
      bit st, rt, ab;
      logic [31:0] rv;
      int p;
      int sh;
      @(posedge clk); #1;
      st = ($urandom_range(0, 99) < 3);
      rt = ($urandom_range(0, 99) < 6);
      ab = ($urandom_range(0, 99) < 2);
      rv = $urandom;
      s_start[0] = st; s_retry[0] = rt; s_abort[0] = ab; s_rnd[0] = rv;
      @(negedge clk);
      chk("rand_busy", o_busy[0], (m_mode == 1));
      chk("rand_expired", o_exp[0], (m_mode == 1 && c == m_dl && !ab));
      chk("rand_exhausted", o_exh[0], m_exh);
      chk("rand_attempt", o_att[0], m_att);
      // model update: the pending window ends at an absolute cycle number
      p = -1;
      if (m_mode == 0) begin
        if (st && !ab) begin m_att = 0; m_exh = 1'b0; p = 0; end
      end else begin
        if (ab) begin
          m_mode = 0; m_att = 0; m_exh = 1'b0;
        end else if (st) begin
          m_att = 0; m_exh = 1'b0; p = 0;
        end else if (rt) begin
          if (m_att < 2) begin m_att++; p = 0; end
          else begin m_exh = 1'b1; m_mode = 0; end
        end else if (m_mode == 1 && c == m_dl) begin
          m_mode = 2;
        end
      end
      if (p == 0) begin
        sh = (m_att > 2) ? 2 : m_att;
        p = (3 << sh) + int'(rv & 32'h3);
        if (p == 0) p = 1;
        m_dl = c + p;
        m_mode = 1;
      end
    end
    @(posedge clk); #1;
    s_start[0] = 1'b0; s_retry[0] = 1'b0; s_abort[0] = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
